// File: rtl/bus_interconnect_if.sv
// rtl/bus_interconnect_if.sv - signal bundle between the bus master, the interconnect and its slaves
interface bus_interconnect_if #(
    parameter int N_SLAVES = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [ADDR_W-1:0]          i_m_addr;
    logic [DATA_W-1:0]          i_m_wdata;
    logic [DATA_W/8-1:0]        i_m_wr;
    logic                       i_m_rd;
    logic [DATA_W-1:0]          o_m_rdata;
    logic                       o_m_ready;
    logic                       o_m_err;
    logic                       o_m_busy;
    logic [N_SLAVES-1:0]        o_s_cs;
    logic [ADDR_W-1:0]          o_s_addr;
    logic [DATA_W-1:0]          o_s_wdata;
    logic [DATA_W/8-1:0]        o_s_wr;
    logic                       o_s_rd;
    logic [N_SLAVES*DATA_W-1:0] i_s_rdata;
    logic [N_SLAVES-1:0]        i_s_ready;

    modport master (
        output i_m_addr, i_m_wdata, i_m_wr, i_m_rd,
        input  o_m_rdata, o_m_ready, o_m_err, o_m_busy
    );

    modport slave (
        input  o_s_cs, o_s_addr, o_s_wdata, o_s_wr, o_s_rd,
        output i_s_rdata, i_s_ready
    );

    modport fabric (
        input  i_m_addr, i_m_wdata, i_m_wr, i_m_rd, i_s_rdata, i_s_ready,
        output o_m_rdata, o_m_ready, o_m_err, o_m_busy,
        output o_s_cs, o_s_addr, o_s_wdata, o_s_wr, o_s_rd
    );
endinterface

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - table-decoded single-master N-slave interconnect; BUS_TIMEOUT_EN adds a wait-state timeout
module bus_interconnect #(
    parameter int                         N_SLAVES      = 3,
    parameter int                         ADDR_W        = 32,
    parameter int                         DATA_W        = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE    = {32'h0000_8010, 32'h0000_8000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK    = {32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_8000},
    parameter logic [DATA_W-1:0]          DEFAULT_RDATA = DATA_W'(32'hDEAD_BEEF),
    parameter int                         TIMEOUT       = 16
) (
    input logic                i_clk,
    input logic                i_rst,
    bus_interconnect_if.fabric bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    if (N_SLAVES < 1 || N_SLAVES > 16 || (DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("bus_interconnect: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [STRB_W-1:0]   wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [N_SLAVES-1:0] cs_q, cs_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit, req, is_read, sel_ready, timed_out;
    logic [DATA_W-1:0]   sel_rdata;

    assign req       = (|bus.i_m_wr) | bus.i_m_rd;
    assign is_read   = bus.i_m_rd & ~(|bus.i_m_wr);
    assign sel_ready = bus.i_s_ready[idx_q];
    assign sel_rdata = bus.i_s_rdata[idx_q*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Fires on the TIMEOUT-th ACCESS cycle without ready.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((bus.i_m_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        cs_d    = cs_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    addr_d  = bus.i_m_addr;
                    wdata_d = bus.i_m_wdata;
                    wr_d    = bus.i_m_wr;
                    rd_d    = is_read;
                    idx_d   = hit_idx;
                    cs_d    = N_SLAVES'(1) << hit_idx;
                    err_d   = 1'b0;
                    state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (req) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = RESP;
                    if (is_read) rdata_d = DEFAULT_RDATA;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                    cs_d    = '0;
                    state_d = RESP;
                    if (rd_q) rdata_d = sel_rdata;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    cs_d    = '0;
                    state_d = RESP;
                    if (rd_q) rdata_d = DEFAULT_RDATA;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= '0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            cs_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            cs_q    <= cs_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_m_rdata = rdata_q;
    assign bus.o_m_ready = ready_q;
    assign bus.o_m_err   = err_q;
    assign bus.o_m_busy  = busy_q;
    assign bus.o_s_cs    = cs_q;
    assign bus.o_s_addr  = addr_q;
    assign bus.o_s_wdata = wdata_q;
    // Strobes only reach the slaves while one of them is selected.
    assign bus.o_s_wr    = wr_q & {STRB_W{|cs_q}};
    assign bus.o_s_rd    = rd_q & (|cs_q);
endmodule
